// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master controller.
package apb_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned REGION_HI = 31;
    localparam int unsigned REGION_LO = 28;

    localparam logic [3:0] PERIPH_REGION_DEF = 4'h1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Request latched from the core at acceptance.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              write;
    } apb_req_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decode: peripheral-region check plus slave index.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES    = 4,
    parameter logic [3:0]  PERIPH_REGION = PERIPH_REGION_DEF,
    parameter int unsigned SEL_LSB       = 12
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              valid_c,
    output logic [IDX_W-1:0]  idx_c
);

    logic unused_addr;

    assign idx_c       = addr[SEL_LSB+IDX_W-1:SEL_LSB];
    assign valid_c     = (addr[REGION_HI:REGION_LO] == PERIPH_REGION) &&
                         (5'(idx_c) < 5'(NUM_SLAVES));
    assign unused_addr = ^addr;

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencing core load/store accesses onto NUM_SLAVES decoded slaves.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter logic [3:0]  PERIPH_REGION  = PERIPH_REGION_DEF,
    parameter int unsigned SEL_LSB        = 12,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         transfer,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata,
    output logic                         ready,
    output logic                         error,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    input  logic [DATA_W*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY
);

    apb_state_e            state_q, state_d;
    apb_req_t              req_q, req_d;
    logic                  valid_q, valid_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic                  dec_valid_c;
    logic [IDX_W-1:0]      dec_idx_c;
    logic                  sel_pready_c;
    logic [DATA_W-1:0]     sel_prdata_c;

`ifdef APB_TIMEOUT_EN
    logic [7:0]            wait_q, wait_d;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

    apb_addr_decoder #(
        .NUM_SLAVES    (NUM_SLAVES),
        .PERIPH_REGION (PERIPH_REGION),
        .SEL_LSB       (SEL_LSB)
    ) u_dec (
        .addr    (addr),
        .valid_c (dec_valid_c),
        .idx_c   (dec_idx_c)
    );

    // Selected slave's response, steered by the registered one-hot select.
    always_comb begin
        sel_prdata_c = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel_q[i]) begin
                sel_prdata_c = sel_prdata_c | PRDATA[DATA_W*i +: DATA_W];
            end
        end
        sel_pready_c = |(PREADY & psel_q);
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        valid_d   = valid_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        rdata_d   = rdata_q;
`ifdef APB_TIMEOUT_EN
        wait_d    = wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    req_d     = '{addr: addr, wdata: wdata, write: write};
                    valid_d   = dec_valid_c;
                    psel_d    = dec_valid_c ? (NUM_SLAVES'(1) << dec_idx_c) : '0;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (valid_q) begin
                    penable_d = 1'b1;
                    state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_d    = 8'd0;
`endif
                end else begin
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    rdata_d = '0;
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (sel_pready_c) begin
                    rdata_d   = req_q.write ? '0 : sel_prdata_c;
                    ready_d   = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (8'(wait_q + 8'd1) == 8'(TIMEOUT_CYCLES)) begin
                    rdata_d   = '0;
                    ready_d   = 1'b1;
                    error_d   = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wait_d = 8'(wait_q + 8'd1);
                end
`endif
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            valid_q   <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= '0;
`ifdef APB_TIMEOUT_EN
            wait_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            rdata_q   <= rdata_d;
`ifdef APB_TIMEOUT_EN
            wait_q    <= wait_d;
`endif
        end
    end

    assign PADDR   = req_q.addr;
    assign PWDATA  = req_q.wdata;
    assign PWRITE  = req_q.write;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign ready   = ready_q;
    assign error   = error_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Randomized self-checking bench for apb_master_ctrl against a transaction-level model.
module tb_apb_master_ctrl;

    localparam int NS      = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              transfer, write;
    logic [31:0]       addr, wdata;
    logic [31:0]       rdata;
    logic              ready, error;
    logic [31:0]       PADDR, PWDATA;
    logic              PWRITE, PENABLE;
    logic [NS-1:0]     PSEL;
    logic [32*NS-1:0]  PRDATA;
    logic [NS-1:0]     PREADY;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    apb_master_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .error    (error),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    task automatic randomize_slaves();
        for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = $urandom;
        PREADY = NS'($urandom);
    endtask

    // Noise on the request inputs while the master is busy; it must be ignored.
    task automatic drive_noise(input bit hold);
        transfer = hold ? 1'b1 : 1'($urandom);
        write    = 1'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
    endtask

    // One complete transaction; expectations come from decode rules and latency arithmetic.
    task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd, input bit hold);
        int         idx;
        bit         v, to;
        int         n_access;
        logic [3:0] exp_psel;
        idx      = int'(a[15:12]);
        v        = (a[31:28] == 4'h1) && (idx < NS);
        exp_psel = v ? 4'(1 << idx) : 4'd0;
        to       = 1'b0;
        n_access = waits + 1;
`ifdef APB_TIMEOUT_EN
        if (waits >= TIMEOUT) begin
            to       = 1'b1;
            n_access = TIMEOUT;
        end
`endif
        transfer = 1'b1; write = wr; addr = a; wdata = wd;
        randomize_slaves();
        @(posedge clk);
        @(negedge clk);
        drive_noise(hold);
        randomize_slaves();
        vectors++;
        if ({PSEL, PENABLE, ready, error} !== {exp_psel, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL setup_ctrl a=%h: psel/en/rdy/err got %b %b %b %b, want %b 0 0 0",
                     a, PSEL, PENABLE, ready, error, exp_psel);
        end
        vectors++;
        if ({PADDR, PWDATA, PWRITE, rdata} !== {a, wd, wr, exp_rdata}) begin
            miscompares++;
            $display("FAIL setup_bus: paddr %h pwdata %h pwrite %b rdata %h, want %h %h %b %h",
                     PADDR, PWDATA, PWRITE, rdata, a, wd, wr, exp_rdata);
        end
        if (v) begin
            for (int k = 0; k < n_access; k++) begin
                @(negedge clk);
                vectors++;
                if ({PSEL, PENABLE, ready, error, PADDR, PWDATA, PWRITE, rdata} !==
                    {exp_psel, 1'b1, 1'b0, 1'b0, a, wd, wr, exp_rdata}) begin
                    miscompares++;
                    $display("FAIL access_hold k=%0d: psel %b en %b rdy %b err %b paddr %h rdata %h, want %b 1 0 0 %h %h",
                             k, PSEL, PENABLE, ready, error, PADDR, rdata, exp_psel, a, exp_rdata);
                end
                drive_noise(hold);
                randomize_slaves();
                PREADY[idx] = !to && (k == waits);
                PRDATA[32*idx +: 32] = rd;
            end
        end
        @(negedge clk);
        exp_rdata = (!v || to || wr) ? 32'd0 : rd;
        vectors++;
        if ({ready, error, rdata, PSEL, PENABLE, PADDR} !==
            {1'b1, (!v || to), exp_rdata, 4'd0, 1'b0, a}) begin
            miscompares++;
            $display("FAIL completion a=%h: rdy %b err %b rdata %h psel %b en %b paddr %h, want 1 %b %h 0000 0 %h",
                     a, ready, error, rdata, PSEL, PENABLE, PADDR, (!v || to), exp_rdata, a);
        end
        transfer = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({rdata, ready, error, PADDR, PWRITE, PWDATA, PSEL, PENABLE} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: rdata %h rdy %b err %b paddr %h pwrite %b pwdata %h psel %b en %b, want all 0",
                     rdata, ready, error, PADDR, PWRITE, PWDATA, PSEL, PENABLE);
        end
    endtask

    task automatic test_store_zero_wait();
        run_txn(1'b1, 32'h1000_2004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    endtask

    task automatic test_load_wait();
        run_txn(1'b0, 32'h1000_1000, 32'h0, 3, 32'h1234_5678, 1'b0);
        vectors++;
        if (rdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL load_rdata_hold: got %h want 12345678", rdata);
        end
    endtask

    task automatic test_unmapped();
        run_txn(1'b0, 32'h2000_0000, 32'h0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 32'h1000_7000, 32'h0, 0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 32'h1000_0010, 32'hAAAA_0001, 1, 32'h0, 1'b1);
        run_txn(1'b1, 32'h1000_3020, 32'hBBBB_0002, 0, 32'h0, 1'b1);
        run_txn(1'b0, 32'h1000_2030, 32'h0, 2, 32'hC0FF_EE00, 1'b0);
    endtask

    task automatic test_reset_mid();
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1040; wdata = 32'h0;
        PREADY = '0;
        @(posedge clk);
        @(negedge clk);
        transfer = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp_rdata = 32'd0;
        vectors++;
        if ({PSEL, PENABLE, ready, error, rdata, PADDR} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: psel %b en %b rdy %b err %b rdata %h paddr %h, want all 0",
                     PSEL, PENABLE, ready, error, rdata, PADDR);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 32'h1000_0000, 32'h0, 1, 32'h5A5A_1234, 1'b0);
    endtask

    task automatic test_long_wait();
        run_txn(1'b0, 32'h1000_3000, 32'h0, 100, 32'h7777_8888, 1'b0);
        run_txn(1'b0, 32'h1000_2000, 32'h0, TIMEOUT - 1, 32'h0101_0202, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          w;
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:28] = 4'h1;
            if ($urandom_range(0, 3) != 0) a[15:12] = 4'($urandom_range(0, NS - 1));
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
            run_txn(1'($urandom), a, $urandom, w, $urandom, 1'($urandom));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                addr = $urandom; wdata = $urandom; write = 1'($urandom);
                @(negedge clk);
                vectors++;
                if ({ready, error, PSEL, PENABLE, rdata} !== {1'b0, 1'b0, 4'd0, 1'b0, exp_rdata}) begin
                    miscompares++;
                    $display("FAIL idle_gap: rdy %b err %b psel %b en %b rdata %h, want 0 0 0000 0 %h",
                             ready, error, PSEL, PENABLE, rdata, exp_rdata);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        PRDATA = '0; PREADY = '0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_store_zero_wait();
        test_load_wait();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        test_long_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
